// File: rtl/traffic_pkg.sv
// Shared definitions for the two-direction traffic-light controller:
// lamp codes, controller states and the BCD digit type.
// The NF state exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
package traffic_pkg;

  localparam logic [1:0] LAMP_OFF    = 2'd0;
  localparam logic [1:0] LAMP_GREEN  = 2'd1;
  localparam logic [1:0] LAMP_YELLOW = 2'd2;
  localparam logic [1:0] LAMP_RED    = 2'd3;

  typedef enum logic [2:0] {
    G1 = 3'd0,
    Y1 = 3'd1,
    G2 = 3'd2,
    Y2 = 3'd3
`ifdef TRAFFIC_NIGHT_FLASH_EN
    , NF = 3'd4
`endif
  } state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational binary-to-BCD split for display values 0..99.
module bin2bcd_2dig
  import traffic_pkg::*;
(
  input  logic [6:0] bin,
  output bcd_t       tens,
  output bcd_t       units
);

  // Tens digit is the largest k with bin >= 10*k; units is what remains.
  always_comb begin
    tens = '0;
    for (int k = 1; k <= 9; k++) begin
      if (bin >= 7'(k * 10)) tens = 4'(k);
    end
    units = 4'(bin - 7'(tens * 10));
  end

endmodule

// File: rtl/traffic_ctrl_param.sv
// Two-direction traffic-light controller with per-direction two-digit
// countdown displays. Timing advances only on tick_en pulses.
// Optional night flashing mode: define TRAFFIC_NIGHT_FLASH_EN.
//
// state | meaning
// G1    | dir1 green, dir2 red
// Y1    | dir1 yellow, dir2 red
// G2    | dir1 red, dir2 green
// Y2    | dir1 red, dir2 yellow
// NF    | night flash, both lamps blink yellow (optional build only)
module traffic_ctrl_param
  import traffic_pkg::*;
#(
  parameter int GREEN_T  = 15,
  parameter int YELLOW_T = 5,
  parameter int PED_T    = 3,
  parameter int CNT_W    = 7
) (
  input  logic       clk2,
  input  logic       reset,
  input  logic       tick_en,
  input  logic       ped_req,
  input  logic       night,
  output logic [1:0] light1,
  output logic [1:0] light2,
  output logic [3:0] light_chuc1,
  output logic [3:0] light_dv1,
  output logic [3:0] light_chuc2,
  output logic [3:0] light_dv2,
  output logic       ped_pending
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q, ped_d;
  logic [CNT_W-1:0] disp1, disp2;
  logic [CNT_W-1:0] cnt_plus_y;

`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic flash_q, flash_d;
`else
  logic unused_night;
  assign unused_night = night;
`endif

  // State, countdown and pedestrian latch registers.
  always_ff @(posedge clk2 or posedge reset) begin
    if (reset) begin
      state_q <= G1;
      cnt_q   <= GREEN_LD;
      ped_q   <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q <= flash_d;
`endif
    end
  end

  // Next state: phase sequencing, countdown, pedestrian cut.
  // ped_req is merged into the latch before the tick is evaluated so a
  // request arriving with the tick already shortens the green.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q | ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    flash_d = flash_q;
`endif
    if (tick_en) begin
      case (state_q)
        G1, G2: begin
          if (ped_d && (cnt_q > PED_LD)) begin
            cnt_d = PED_LD;
          end else if (cnt_q == ONE) begin
            state_d = (state_q == G1) ? Y1 : Y2;
            cnt_d   = YELLOW_LD;
            ped_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        Y1: begin
          if (cnt_q == ONE) begin
            state_d = G2;
            cnt_d   = GREEN_LD;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        Y2: begin
          if (cnt_q == ONE) begin
            state_d = G1;
            cnt_d   = GREEN_LD;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            if (night) begin
              state_d = NF;
              cnt_d   = '0;
              flash_d = 1'b1;
            end
`endif
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
`ifdef TRAFFIC_NIGHT_FLASH_EN
        NF: begin
          if (!night) begin
            state_d = G1;
            cnt_d   = GREEN_LD;
          end else begin
            flash_d = ~flash_q;
          end
        end
`endif
        default: begin
          state_d = G1;
          cnt_d   = GREEN_LD;
        end
      endcase
    end
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if ((state_q == NF) || (state_d == NF)) ped_d = 1'b0;
`endif
  end

  assign cnt_plus_y = cnt_q + YELLOW_LD;

  // Lamp and display decode. The red side shows ticks until its own green.
  always_comb begin
    light1 = LAMP_OFF;
    light2 = LAMP_OFF;
    disp1  = '0;
    disp2  = '0;
    case (state_q)
      G1: begin
        light1 = LAMP_GREEN;
        light2 = LAMP_RED;
        disp1  = cnt_q;
        disp2  = cnt_plus_y;
      end
      Y1: begin
        light1 = LAMP_YELLOW;
        light2 = LAMP_RED;
        disp1  = cnt_q;
        disp2  = cnt_q;
      end
      G2: begin
        light1 = LAMP_RED;
        light2 = LAMP_GREEN;
        disp1  = cnt_plus_y;
        disp2  = cnt_q;
      end
      Y2: begin
        light1 = LAMP_RED;
        light2 = LAMP_YELLOW;
        disp1  = cnt_q;
        disp2  = cnt_q;
      end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      NF: begin
        light1 = flash_q ? LAMP_YELLOW : LAMP_OFF;
        light2 = flash_q ? LAMP_YELLOW : LAMP_OFF;
      end
`endif
      default: begin
        light1 = LAMP_OFF;
        light2 = LAMP_OFF;
      end
    endcase
  end

  assign ped_pending = ped_q;

  bin2bcd_2dig u_bcd1 (
    .bin   (7'(disp1)),
    .tens  (light_chuc1),
    .units (light_dv1)
  );

  bin2bcd_2dig u_bcd2 (
    .bin   (7'(disp2)),
    .tens  (light_chuc2),
    .units (light_dv2)
  );

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Self-checking bench for traffic_ctrl_param: a phase/remaining-time model
// checked against the DUT every cycle, plus literal spot checks.
module tb_traffic_ctrl_param;

  localparam int G = 15;
  localparam int Y = 5;
  localparam int P = 3;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  localparam bit NF_EN = 1'b1;
`else
  localparam bit NF_EN = 1'b0;
`endif

  logic       clk2 = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       ped_req = 1'b0;
  logic       night = 1'b0;
  logic [1:0] light1, light2;
  logic [3:0] light_chuc1, light_dv1, light_chuc2, light_dv2;
  logic       ped_pending;

  int total = 0;
  int bad   = 0;

  traffic_ctrl_param #(.GREEN_T(G), .YELLOW_T(Y), .PED_T(P), .CNT_W(7)) dut (
    .clk2        (clk2),
    .reset       (reset),
    .tick_en     (tick_en),
    .ped_req     (ped_req),
    .night       (night),
    .light1      (light1),
    .light2      (light2),
    .light_chuc1 (light_chuc1),
    .light_dv1   (light_dv1),
    .light_chuc2 (light_chuc2),
    .light_dv2   (light_dv2),
    .ped_pending (ped_pending)
  );

  always #5 clk2 = ~clk2;

  // Model: phase 0..3 = dir1 green, dir1 yellow, dir2 green, dir2 yellow;
  // phase 4 = night flash. m_rem = ticks left in the phase.
  int m_ph, m_rem;
  bit m_ped, m_flash;

  always @(posedge clk2 or posedge reset) begin : model
    int ph, rem;
    bit pd, fl;
    if (reset) begin
      m_ph    <= 0;
      m_rem   <= G;
      m_ped   <= 1'b0;
      m_flash <= 1'b0;
    end else begin
      ph  = m_ph;
      rem = m_rem;
      fl  = m_flash;
      pd  = (ph == 4) ? 1'b0 : (m_ped | ped_req);
      if (tick_en) begin
        if (ph == 4) begin
          if (!night) begin ph = 0; rem = G; end
          else fl = !fl;
        end else if ((ph == 0 || ph == 2) && pd && rem > P) begin
          rem = P;
        end else if (rem > 1) begin
          rem = rem - 1;
        end else if (ph == 3 && NF_EN && night) begin
          ph = 4; rem = 0; fl = 1'b1; pd = 1'b0;
        end else begin
          ph  = (ph + 1) % 4;
          rem = (ph == 1 || ph == 3) ? Y : G;
          if (ph == 1 || ph == 3) pd = 1'b0;
        end
      end
      m_ph    <= ph;
      m_rem   <= rem;
      m_ped   <= pd;
      m_flash <= fl;
    end
  end

  function automatic int exp_lamp(int dir);
    case (m_ph)
      0: return (dir == 1) ? 1 : 3;
      1: return (dir == 1) ? 2 : 3;
      2: return (dir == 1) ? 3 : 1;
      3: return (dir == 1) ? 3 : 2;
      default: return m_flash ? 2 : 0;
    endcase
  endfunction

  // Active side shows remaining time; red side shows ticks until own green.
  function automatic int exp_disp(int dir);
    bit own;
    if (m_ph == 4) return 0;
    own = (dir == 1) ? (m_ph < 2) : (m_ph >= 2);
    if (own) return m_rem;
    if (m_ph == 0 || m_ph == 2) return m_rem + Y;
    return m_rem;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  task automatic compare_all();
    chk("light1", int'(light1), exp_lamp(1));
    chk("light2", int'(light2), exp_lamp(2));
    chk("chuc1", int'(light_chuc1), exp_disp(1) / 10);
    chk("dv1", int'(light_dv1), exp_disp(1) % 10);
    chk("chuc2", int'(light_chuc2), exp_disp(2) / 10);
    chk("dv2", int'(light_dv2), exp_disp(2) % 10);
    chk("ped_pending", int'(ped_pending), int'(m_ped));
  endtask

  task automatic lit(input string nm, input int l1, input int l2, input int d1, input int d2);
    chk({nm, "_l1"}, int'(light1), l1);
    chk({nm, "_l2"}, int'(light2), l2);
    chk({nm, "_d1"}, int'(light_chuc1) * 10 + int'(light_dv1), d1);
    chk({nm, "_d2"}, int'(light_chuc2) * 10 + int'(light_dv2), d2);
  endtask

  task automatic cyc(input bit t, input bit p);
    tick_en = t;
    ped_req = p;
    @(posedge clk2);
    @(negedge clk2);
    tick_en = 1'b0;
    ped_req = 1'b0;
    compare_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b0);
    end
  endtask

  initial begin
    @(negedge clk2);
    @(negedge clk2);
    compare_all();
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    lit("reset", 1, 3, 15, 20);
    chk("reset_ped", int'(ped_pending), 0);

    ticks(14);
    lit("g1_last", 1, 3, 1, 6);
    ticks(1);
    lit("y1_entry", 2, 3, 5, 5);

    ticks(25);
    lit("cycle_back", 1, 3, 15, 20);

    ticks(3);
    lit("g1_cnt12", 1, 3, 12, 17);
    cyc(1'b0, 1'b1);
    chk("ped_latched", int'(ped_pending), 1);
    ticks(1);
    lit("ped_cut", 1, 3, 3, 8);
    chk("ped_after_cut", int'(ped_pending), 1);
    ticks(3);
    lit("ped_y1", 2, 3, 5, 5);
    chk("ped_cleared", int'(ped_pending), 0);

    ticks(25);
    ticks(13);
    lit("g1_cnt2", 1, 3, 2, 7);
    cyc(1'b0, 1'b1);
    ticks(1);
    lit("no_cut", 1, 3, 1, 6);
    ticks(1);
    lit("no_cut_y1", 2, 3, 5, 5);
    cyc(1'b0, 1'b1);
    chk("ped_in_y1", int'(ped_pending), 1);
    ticks(5);
    lit("g2_entry", 3, 1, 20, 15);
    chk("ped_held_g2", int'(ped_pending), 1);
    ticks(1);
    lit("g2_cut", 3, 1, 8, 3);

    ticks(3 + 5 + 20 + 8);
    lit("g2_cnt7", 3, 1, 12, 7);
    tick_en = 1'b1;
    reset = 1'b1;
    @(posedge clk2);
    @(negedge clk2);
    compare_all();
    lit("mid_reset", 1, 3, 15, 20);
    tick_en = 1'b0;
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    lit("post_reset", 1, 3, 15, 20);

    night = 1'b1;
    ticks(40);
`ifdef TRAFFIC_NIGHT_FLASH_EN
    lit("nf_entry", 2, 2, 0, 0);
    cyc(1'b0, 1'b1);
    chk("nf_ped", int'(ped_pending), 0);
    ticks(1);
    lit("nf_off", 0, 0, 0, 0);
    ticks(1);
    lit("nf_on", 2, 2, 0, 0);
    night = 1'b0;
    ticks(1);
    lit("nf_exit", 1, 3, 15, 20);
`else
    lit("night_ignored", 1, 3, 15, 20);
    night = 1'b0;
    ticks(1);
    lit("night_ignored_tick", 1, 3, 14, 19);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
